window_read_sequencer: RTL and testbench

Controller that sequences feature-map RAM reads for one convolution layer pass. It walks a KSIZE×KSIZE window across a W×H map with a programmable stride. For every window it emits the read addresses on a valid/ready stream. It owns the window-base accumulator, which advances the read lower limit by stride (programmed as stride−1, added with +1). It sits between the layer control FSM and the feature-map RAM read port.

---
 rtl/window_read_sequencer_pkg.sv | 19 +
 rtl/window_read_sequencer_if.sv | 34 +++
 rtl/window_read_sequencer_window_base_acc.sv | 41 ++++
 rtl/window_read_sequencer.sv | 174 +++++++++++++++++
 tb/tb_window_read_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/window_read_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// window_read_sequencer_pkg
// Shared definitions for the window read sequencer:
//   - state_e  : controller state encoding (3 bits)
//   - STRIDE_W : width of the programmed stride-minus-one field
// -----------------------------------------------------------------------------
package window_read_sequencer_pkg;

   localparam int STRIDE_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_ADVANCE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

endpackage

// File: rtl/window_read_sequencer_if.sv
// -----------------------------------------------------------------------------
// window_read_sequencer_if
// Valid/ready read-address stream between the sequencer and the feature-map
// RAM read port.
//   Rd_Valid  : address valid (sequencer -> RAM)
//   Rd_Ready  : RAM side accepts the address (RAM -> sequencer)
//   Rd_Addr   : read address, BITWIDTH bits
//   Win_Last  : marks the last address of the current window
// Modports: master = sequencer side, slave = RAM side.
// -----------------------------------------------------------------------------
interface window_read_sequencer_if #(
   parameter int BITWIDTH = 10
);

   logic                WINDOW_READ_SEQUENCER_Rd_Valid;
   logic                WINDOW_READ_SEQUENCER_Rd_Ready;
   logic [BITWIDTH-1:0] WINDOW_READ_SEQUENCER_Rd_Addr;
   logic                WINDOW_READ_SEQUENCER_Win_Last;

   modport master (
      output WINDOW_READ_SEQUENCER_Rd_Valid,
      output WINDOW_READ_SEQUENCER_Rd_Addr,
      output WINDOW_READ_SEQUENCER_Win_Last,
      input  WINDOW_READ_SEQUENCER_Rd_Ready
   );

   modport slave (
      input  WINDOW_READ_SEQUENCER_Rd_Valid,
      input  WINDOW_READ_SEQUENCER_Rd_Addr,
      input  WINDOW_READ_SEQUENCER_Win_Last,
      output WINDOW_READ_SEQUENCER_Rd_Ready
   );

endinterface

// File: rtl/window_read_sequencer_window_base_acc.sv
// -----------------------------------------------------------------------------
// window_base_acc
// Window-base address register. Holds the address of the top-left pixel of
// the current window.
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low clear
//   load_i       : synchronous load of load_val_i (has priority)
//   load_val_i   : value to load (new row base, or 0 at pass start)
//   acc_en_i     : add stride (stride_m1_i + 1) to the base
//   stride_m1_i  : programmed stride minus one
//   base_o       : current window base (modulo 2^BITWIDTH)
// -----------------------------------------------------------------------------
module window_base_acc
   import window_read_sequencer_pkg::*;
#(
   parameter int BITWIDTH = 10
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                load_i,
   input  logic [BITWIDTH-1:0] load_val_i,
   input  logic                acc_en_i,
   input  logic [STRIDE_W-1:0] stride_m1_i,
   output logic [BITWIDTH-1:0] base_o
);

   logic [BITWIDTH-1:0] base_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         base_q <= '0;
      end else if (load_i) begin
         base_q <= load_val_i;
      end else if (acc_en_i) begin
         base_q <= base_q + BITWIDTH'(stride_m1_i) + BITWIDTH'(1);
      end
   end

   assign base_o = base_q;

endmodule

// File: rtl/window_read_sequencer.sv
// -----------------------------------------------------------------------------
// window_read_sequencer
// Walks a KSIZE x KSIZE window across a W x H feature map with stride 1..4
// and emits every window's read addresses on a valid/ready stream.
//   WINDOW_READ_SEQUENCER_clk        : clock, rising edge
//   WINDOW_READ_SEQUENCER_Reset      : asynchronous active-low reset
//   WINDOW_READ_SEQUENCER_Start      : start pulse, sampled in IDLE only
//   WINDOW_READ_SEQUENCER_Img_Width  : map width W (latched at Start)
//   WINDOW_READ_SEQUENCER_Img_Height : map height H (latched at Start)
//   WINDOW_READ_SEQUENCER_Stride_M1  : stride - 1 (latched at Start)
//   rd                               : read-address stream (master side)
//   WINDOW_READ_SEQUENCER_Busy       : high outside IDLE
//   WINDOW_READ_SEQUENCER_Done       : one-cycle end-of-pass pulse
//   WINDOW_READ_SEQUENCER_Error      : with Done, map smaller than kernel
// -----------------------------------------------------------------------------
module window_read_sequencer
   import window_read_sequencer_pkg::*;
#(
   parameter int BITWIDTH = 10,
   parameter int KSIZE    = 3,
   parameter int CNT_W    = 8
) (
   input  logic                WINDOW_READ_SEQUENCER_clk,
   input  logic                WINDOW_READ_SEQUENCER_Reset,
   input  logic                WINDOW_READ_SEQUENCER_Start,
   input  logic [CNT_W-1:0]    WINDOW_READ_SEQUENCER_Img_Width,
   input  logic [CNT_W-1:0]    WINDOW_READ_SEQUENCER_Img_Height,
   input  logic [STRIDE_W-1:0] WINDOW_READ_SEQUENCER_Stride_M1,
   window_read_sequencer_if.master rd,
   output logic                WINDOW_READ_SEQUENCER_Busy,
   output logic                WINDOW_READ_SEQUENCER_Done,
   output logic                WINDOW_READ_SEQUENCER_Error
);

   localparam logic [CNT_W-1:0] K_LAST = CNT_W'(KSIZE - 1);
   localparam logic [CNT_W:0]   K_EXT  = (CNT_W+1)'(KSIZE);

   state_e              state_q;
   logic [CNT_W-1:0]    w_q, h_q, kc_q, kr_q, wc_q, wr_q;
   logic [STRIDE_W-1:0] sm1_q;
   logic                err_q;
   logic [BITWIDTH-1:0] line_q, row_base_q, win_base_q;

   logic [BITWIDTH-1:0] w_addr_d, sw_d, row_base_d, load_val_d, addr_d;
   logic [CNT_W-1:0]    s_cnt_d;
   logic [CNT_W:0]      s_ext_d;
   logic                col_fit_d, row_fit_d, too_small_d;
   logic                kc_wrap_d, win_end_d, load_d, acc_d;

   always_comb begin
      s_cnt_d     = CNT_W'(sm1_q) + CNT_W'(1);
      s_ext_d     = (CNT_W+1)'(sm1_q) + (CNT_W+1)'(1);
      // One extra bit so wc+S+KSIZE cannot wrap near the top of the range.
      col_fit_d   = ({1'b0, wc_q} + s_ext_d + K_EXT) <= {1'b0, w_q};
      row_fit_d   = ({1'b0, wr_q} + s_ext_d + K_EXT) <= {1'b0, h_q};
      too_small_d = ({1'b0, w_q} < K_EXT) || ({1'b0, h_q} < K_EXT);
      w_addr_d    = BITWIDTH'(w_q);
      // S*W for S in 1..4 as a shift-add, no multiplier.
      sw_d        = w_addr_d;
      case (sm1_q)
         2'd0: sw_d = w_addr_d;
         2'd1: sw_d = w_addr_d << 1;
         2'd2: sw_d = (w_addr_d << 1) + w_addr_d;
         2'd3: sw_d = w_addr_d << 2;
      endcase
      row_base_d  = row_base_q + sw_d;
      kc_wrap_d   = (kc_q == K_LAST);
      win_end_d   = kc_wrap_d && (kr_q == K_LAST);
      // Base register: cleared in CHECK, reloaded on a row step, bumped on a column step.
      load_d      = (state_q == ST_CHECK) ||
                    ((state_q == ST_ADVANCE) && !col_fit_d && row_fit_d);
      load_val_d  = (state_q == ST_CHECK) ? '0 : row_base_d;
      acc_d       = (state_q == ST_ADVANCE) && col_fit_d;
      addr_d      = win_base_q + line_q + BITWIDTH'(kc_q);
   end

   window_base_acc #(
      .BITWIDTH (BITWIDTH)
   ) u_window_base_acc (
      .clk_i       (WINDOW_READ_SEQUENCER_clk),
      .rst_ni      (WINDOW_READ_SEQUENCER_Reset),
      .load_i      (load_d),
      .load_val_i  (load_val_d),
      .acc_en_i    (acc_d),
      .stride_m1_i (sm1_q),
      .base_o      (win_base_q)
   );

   always_ff @(posedge WINDOW_READ_SEQUENCER_clk or negedge WINDOW_READ_SEQUENCER_Reset) begin
      if (!WINDOW_READ_SEQUENCER_Reset) begin
         state_q    <= ST_IDLE;
         w_q        <= '0;
         h_q        <= '0;
         sm1_q      <= '0;
         err_q      <= 1'b0;
         kc_q       <= '0;
         kr_q       <= '0;
         wc_q       <= '0;
         wr_q       <= '0;
         line_q     <= '0;
         row_base_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (WINDOW_READ_SEQUENCER_Start) begin
                  w_q     <= WINDOW_READ_SEQUENCER_Img_Width;
                  h_q     <= WINDOW_READ_SEQUENCER_Img_Height;
                  sm1_q   <= WINDOW_READ_SEQUENCER_Stride_M1;
                  err_q   <= 1'b0;
                  state_q <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               kc_q       <= '0;
               kr_q       <= '0;
               wc_q       <= '0;
               wr_q       <= '0;
               line_q     <= '0;
               row_base_q <= '0;
               if (too_small_d) begin
                  err_q   <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (rd.WINDOW_READ_SEQUENCER_Rd_Ready) begin
                  if (kc_wrap_d) begin
                     kc_q <= '0;
                     if (win_end_d) begin
                        kr_q    <= '0;
                        line_q  <= '0;
                        state_q <= ST_ADVANCE;
                     end else begin
                        kr_q   <= kr_q + CNT_W'(1);
                        line_q <= line_q + w_addr_d;
                     end
                  end else begin
                     kc_q <= kc_q + CNT_W'(1);
                  end
               end
            end
            ST_ADVANCE: begin
               if (col_fit_d) begin
                  wc_q    <= wc_q + s_cnt_d;
                  state_q <= ST_ISSUE;
               end else if (row_fit_d) begin
                  wc_q       <= '0;
                  wr_q       <= wr_q + s_cnt_d;
                  row_base_q <= row_base_d;
                  state_q    <= ST_ISSUE;
               end else begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rd.WINDOW_READ_SEQUENCER_Rd_Valid = (state_q == ST_ISSUE);
   assign rd.WINDOW_READ_SEQUENCER_Rd_Addr  = addr_d;
   assign rd.WINDOW_READ_SEQUENCER_Win_Last = (state_q == ST_ISSUE) && win_end_d;
   assign WINDOW_READ_SEQUENCER_Busy        = (state_q != ST_IDLE);
   assign WINDOW_READ_SEQUENCER_Done        = (state_q == ST_DONE);
   assign WINDOW_READ_SEQUENCER_Error       = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_window_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_window_read_sequencer
// Scoreboard bench: the expected address stream of a pass is built from the
// window geometry and compared handshake by handshake. Instance A uses a
// 10-bit address, instance B a 4-bit address for the wrap-around case.
// -----------------------------------------------------------------------------
module tb_window_read_sequencer;

   localparam int K = 3;

   typedef struct {
      int addr;
      bit last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic [7:0] img_w = 8'd5;
   logic [7:0] img_h = 8'd5;
   logic [1:0] stride_m1 = 2'd0;
   logic       ready = 1'b1;
   logic       busy_a, done_a, error_a;
   logic       busy_b, done_b, error_b;

   int   n_vec = 0;
   int   n_err = 0;
   int   n_hs  = 0;
   bit   sel = 1'b0;
   bit   mon_en = 1'b0;
   exp_t exp_q[$];

   // monitor state
   logic mv, ml, pl;
   int   ma, pa;
   bit   stall_prev = 1'b0;
   exp_t e;

   always #5 clk = ~clk;

   window_read_sequencer_if #(.BITWIDTH(10)) ifa ();
   window_read_sequencer_if #(.BITWIDTH(4))  ifb ();

   assign ifa.WINDOW_READ_SEQUENCER_Rd_Ready = ready;
   assign ifb.WINDOW_READ_SEQUENCER_Rd_Ready = ready;

   window_read_sequencer #(.BITWIDTH(10), .KSIZE(K), .CNT_W(8)) dut_a (
      .WINDOW_READ_SEQUENCER_clk        (clk),
      .WINDOW_READ_SEQUENCER_Reset      (rst_n),
      .WINDOW_READ_SEQUENCER_Start      (start_a),
      .WINDOW_READ_SEQUENCER_Img_Width  (img_w),
      .WINDOW_READ_SEQUENCER_Img_Height (img_h),
      .WINDOW_READ_SEQUENCER_Stride_M1  (stride_m1),
      .rd                               (ifa.master),
      .WINDOW_READ_SEQUENCER_Busy       (busy_a),
      .WINDOW_READ_SEQUENCER_Done       (done_a),
      .WINDOW_READ_SEQUENCER_Error      (error_a)
   );

   window_read_sequencer #(.BITWIDTH(4), .KSIZE(K), .CNT_W(8)) dut_b (
      .WINDOW_READ_SEQUENCER_clk        (clk),
      .WINDOW_READ_SEQUENCER_Reset      (rst_n),
      .WINDOW_READ_SEQUENCER_Start      (start_b),
      .WINDOW_READ_SEQUENCER_Img_Width  (img_w),
      .WINDOW_READ_SEQUENCER_Img_Height (img_h),
      .WINDOW_READ_SEQUENCER_Stride_M1  (stride_m1),
      .rd                               (ifb.master),
      .WINDOW_READ_SEQUENCER_Busy       (busy_b),
      .WINDOW_READ_SEQUENCER_Done       (done_b),
      .WINDOW_READ_SEQUENCER_Error      (error_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic logic busy_of(input bit s);
      return s ? busy_b : busy_a;
   endfunction

   function automatic logic done_of(input bit s);
      return s ? done_b : done_a;
   endfunction

   function automatic logic error_of(input bit s);
      return s ? error_b : error_a;
   endfunction

   // Handshake monitor: sampled on the falling edge, i.e. the values the
   // next rising edge will act on.
   always @(negedge clk) begin
      mv = sel ? ifb.WINDOW_READ_SEQUENCER_Rd_Valid : ifa.WINDOW_READ_SEQUENCER_Rd_Valid;
      ml = sel ? ifb.WINDOW_READ_SEQUENCER_Win_Last : ifa.WINDOW_READ_SEQUENCER_Win_Last;
      ma = sel ? int'(ifb.WINDOW_READ_SEQUENCER_Rd_Addr) : int'(ifa.WINDOW_READ_SEQUENCER_Rd_Addr);
      if (rst_n && mon_en) begin
         if (stall_prev) begin
            check("hold_valid", mv, 1'b1);
            check("hold_addr", ma, pa);
            check("hold_last", ml, pl);
         end
         if (mv && ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_handshake", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("addr", ma, e.addr);
               check("win_last", ml, e.last);
               n_hs++;
               $display("txn %s #%0d addr=%0d last=%0d", sel ? "B" : "A", n_hs, ma, ml);
            end
         end
         stall_prev = mv && !ready;
         pa = ma;
         pl = ml;
      end else begin
         stall_prev = 1'b0;
      end
   end

   // One full pass: build the expected stream, start, wait for Done, check
   // the pass-level results. inj >= 1 fires a Start (with different config)
   // at that cycle of the pass, which must be ignored.
   task automatic run_pass(input bit selb, input int w, input int h, input int sm1,
                           input bit rnd, input int inj);
      int s, nwin, bw, cyc, mask;
      bit exp_err;
      s       = sm1 + 1;
      bw      = selb ? 4 : 10;
      mask    = (1 << bw) - 1;
      exp_err = (w < K) || (h < K);
      nwin    = exp_err ? 0 : ((w - K) / s + 1) * ((h - K) / s + 1);
      exp_q.delete();
      if (!exp_err) begin
         for (int wr = 0; wr + K <= h; wr += s)
            for (int wc = 0; wc + K <= w; wc += s)
               for (int kr = 0; kr < K; kr++)
                  for (int kc = 0; kc < K; kc++)
                     exp_q.push_back('{((wr + kr) * w + wc + kc) & mask,
                                       (kr == K - 1) && (kc == K - 1)});
      end
      sel       = selb;
      n_hs      = 0;
      ready     = 1'b1;
      img_w     = 8'(w);
      img_h     = 8'(h);
      stride_m1 = 2'(sm1);
      mon_en    = 1'b1;
      @(posedge clk); #1;
      if (selb) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      cyc = 1;
      check("busy_in_check", busy_of(selb), 1'b1);
      while (done_of(selb) !== 1'b1 && cyc < 20000) begin
         ready     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start_a   = (cyc == inj);
         img_w     = (cyc == inj) ? 8'(w + 3) : 8'(w);
         stride_m1 = (cyc == inj) ? 2'(sm1 + 1) : 2'(sm1);
         @(posedge clk); #1;
         cyc++;
      end
      start_a   = 1'b0;
      img_w     = 8'(w);
      stride_m1 = 2'(sm1);
      check("done_seen", done_of(selb), 1'b1);
      check("error", error_of(selb), exp_err);
      if (!rnd) check("done_cycle", cyc, 2 + nwin * (K * K + 1));
      check("handshakes", n_hs, nwin * K * K);
      check("queue_left", exp_q.size(), 0);
      check("busy_in_done", busy_of(selb), 1'b1);
      ready = 1'b1;
      @(posedge clk); #1;
      check("done_pulse", done_of(selb), 1'b0);
      check("error_after", error_of(selb), 1'b0);
      check("busy_after", busy_of(selb), 1'b0);
      mon_en = 1'b0;
      $display("pass %s W=%0d H=%0d S=%0d windows=%0d handshakes=%0d cycles=%0d",
               selb ? "B" : "A", w, h, s, nwin, n_hs, cyc);
   endtask

   initial begin
      // reset values
      #1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", ifa.WINDOW_READ_SEQUENCER_Rd_Valid, 1'b0);
      check("rst_addr", ifa.WINDOW_READ_SEQUENCER_Rd_Addr, 0);
      check("rst_last", ifa.WINDOW_READ_SEQUENCER_Win_Last, 1'b0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_error", error_a, 1'b0);
      rst_n = 1'b1;

      run_pass(1'b0, 5, 5, 0, 1'b0, -1);   // 9 windows, stride 1
      run_pass(1'b0, 5, 5, 1, 1'b0, -1);   // 4 windows, stride 2
      run_pass(1'b0, 5, 5, 0, 1'b1, -1);   // random backpressure
      run_pass(1'b0, 2, 5, 0, 1'b0, -1);   // map too narrow
      run_pass(1'b0, 8, 7, 2, 1'b0, -1);   // stride 3, trailing pixels skipped
      run_pass(1'b0, 6, 4, 3, 1'b1, -1);   // stride 4, single window row

      // reset in the middle of ISSUE
      sel = 1'b0;
      mon_en = 1'b0;
      img_w = 8'd5;
      img_h = 8'd5;
      stride_m1 = 2'd0;
      ready = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      check("mid_valid", ifa.WINDOW_READ_SEQUENCER_Rd_Valid, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_valid", ifa.WINDOW_READ_SEQUENCER_Rd_Valid, 1'b0);
      check("abort_addr", ifa.WINDOW_READ_SEQUENCER_Rd_Addr, 0);
      check("abort_last", ifa.WINDOW_READ_SEQUENCER_Win_Last, 1'b0);
      check("abort_busy", busy_a, 1'b0);
      check("abort_done", done_a, 1'b0);
      check("abort_error", error_a, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_pass(1'b0, 5, 5, 0, 1'b0, 20);   // restart from 0, stray Start ignored
      run_pass(1'b1, 6, 6, 0, 1'b0, -1);   // 4-bit address wrap

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
